cond_gen_elastic_pipe: RTL

- Parametrised valid/ready elastic buffer. Its internal structure is chosen by conditional generate: zero-depth bypass, a register-slice chain, or a circular FIFO.
- Successor to the fixed single-register slices instantiated inside generate-if branches. One module now covers depth, width and mode, and adds occupancy reporting and flush.
- Sits between any producer/consumer pair in a datapath.

---
 rtl/cond_gen_elastic_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cond_gen_elastic_pipe.sv
// Valid/ready elastic buffer: zero-depth bypass, bubble-collapsing register chain, or circular FIFO.
// Define COND_GEN_ELASTIC_PIPE_STATS_EN to add stall/transfer counters (stats_clr, stall_cnt, xfer_cnt).
module cond_gen_elastic_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned MODE  = 0,
    localparam int unsigned LW   = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    level
`ifdef COND_GEN_ELASTIC_PIPE_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      xfer_cnt
`endif
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_bypass;

        assign out_valid     = in_valid;
        assign out_data      = in_data;
        assign in_ready      = out_ready;
        assign level         = '0;
        assign unused_bypass = ^{clk, rst, flush};

    end else if (MODE == 0) begin : g_chain
        logic [DEPTH-1:0] v_q;
        logic [DEPTH-1:0] v_d;
        logic [DEPTH-1:0] rdy;
        logic [WIDTH-1:0] d_q [DEPTH];

        // A stage may load when it is empty or anything downstream of it can move.
        always_comb begin
            logic acc;
            acc = out_ready;
            rdy = '0;
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                acc    = acc | ~v_q[i];
                rdy[i] = acc;
            end
        end

        always_comb begin
            v_d = v_q;
            if (rdy[0]) v_d[0] = in_valid;
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (rdy[i]) v_d[i] = v_q[i-1];
            end
            if (flush) v_d = '0;
        end

        always_ff @(posedge clk) begin
            if (rst) v_q <= '0;
            else     v_q <= v_d;
        end

        always_ff @(posedge clk) begin
            if (rdy[0]) d_q[0] <= in_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (rdy[i]) d_q[i] <= d_q[i-1];
            end
        end

        assign in_ready  = rdy[0] & ~flush;
        assign out_valid = v_q[DEPTH-1] & ~flush;
        assign out_data  = d_q[DEPTH-1];
        assign level     = LW'($countones(v_q));

    end else if (MODE == 1) begin : g_fifo
        localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [LW-1:0]    cnt_q, cnt_d;
        logic             push, pop;

        function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
            return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
        endfunction

        assign in_ready  = (cnt_q < LW'(DEPTH)) && !flush;
        assign out_valid = (cnt_q != '0) && !flush;
        assign out_data  = mem_q[rd_ptr_q];
        assign level     = cnt_q;
        assign push      = in_valid && in_ready;
        assign pop       = out_valid && out_ready;

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push) wr_ptr_d = wrap_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
            if (push && !pop)      cnt_d = cnt_q + LW'(1);
            else if (pop && !push) cnt_d = cnt_q - LW'(1);
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q] <= in_data;
        end

    end else begin : g_bad_mode
        $error("cond_gen_elastic_pipe: MODE must be 0 (chain) or 1 (FIFO)");
    end

`ifdef COND_GEN_ELASTIC_PIPE_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] xfer_cnt_q;

    // Stall count saturates, transfer count wraps; clear beats a same-cycle event.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (out_valid && out_ready) xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign xfer_cnt  = xfer_cnt_q;
`endif

    if (DEPTH > 0) begin : g_chk
        a_level_bound: assert property (@(posedge clk) disable iff (rst) level <= LW'(DEPTH));
        a_data_hold:   assert property (@(posedge clk) disable iff (rst)
                                        (out_valid && !out_ready) |=> $stable(out_data));
    end

endmodule
